// File: rtl/decode_stage.sv
// decode_stage: decodes one instruction at a time, fetches up to two vector sources
// over the register-file read port and issues one packet to execute.
// Optional build macro DECODE_ILLEGAL_TRAP_EN: illegal opcodes issue a TRAP packet.
module decode_stage #(
    parameter int NUM_LANES = 8,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_ID_W  = 5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        fetch_valid,
    output logic                        fetch_ready,
    input  logic [31:0]                 fetch_instr,
    input  logic [ADDR_W-1:0]           fetch_pc,
    input  logic [NUM_LANES-1:0]        fetch_mask,
    input  logic                        flush,
    output logic                        rf_rd_req,
    output logic [REG_ID_W-1:0]         rf_rd_id,
    input  logic                        rf_rd_valid,
    input  logic [NUM_LANES*WORD_W-1:0] rf_rd_data,
    input  logic                        dx_is_busy,
    output logic                        dx_send,
    output logic [2:0]                  dx_kind,
    output logic [NUM_LANES-1:0]        dx_exec_mask,
    output logic [ADDR_W-1:0]           dx_pc,
    output logic [5:0]                  dx_opcode,
    output logic [REG_ID_W-1:0]         dx_value0_reg,
    output logic [NUM_LANES*WORD_W-1:0] dx_value0_vec,
    output logic [NUM_LANES*WORD_W-1:0] dx_value1,
    output logic [NUM_LANES*WORD_W-1:0] dx_value2,
    output logic                        illegal_seen
);

    localparam int VEC_W = NUM_LANES * WORD_W;

    localparam logic [2:0] K_REQ0     = 3'd0;
    localparam logic [2:0] K_REQ1     = 3'd1;
    localparam logic [2:0] K_REQ2_REG = 3'd2;
    localparam logic [2:0] K_REQ2_VEC = 3'd3;
    localparam logic [2:0] K_REQ3_REG = 3'd4;
    localparam logic [2:0] K_REQ3_VEC = 3'd5;

    typedef enum logic [2:0] {IDLE, READ_A, WAIT_A, READ_B, WAIT_B, ISSUE} state_t;

    state_t              state, state_next;
    logic [5:0]          op;
    logic [2:0]          dec_kind;
    logic                dec_legal, dec_need_a, dec_need_b;
    logic [VEC_W-1:0]    imm_v;
    logic [REG_ID_W-1:0] src_a, src_b;
    logic                need_b;
    logic                accept, cap_a, cap_b;

    function automatic logic [VEC_W-1:0] imm_vec(input logic [10:0] imm11);
        logic signed [WORD_W-1:0] word;
        word = WORD_W'($signed(imm11));
        return {NUM_LANES{word}};
    endfunction

    assign op    = fetch_instr[31:26];
    assign imm_v = imm_vec(fetch_instr[10:0]);

    always_comb begin
        dec_kind   = K_REQ0;
        dec_legal  = 1'b1;
        dec_need_a = 1'b0;
        dec_need_b = 1'b0;
        case (op)
            6'h00, 6'h01: dec_kind = K_REQ0;
            6'h06:        dec_kind = K_REQ1;
            6'h02:        dec_kind = K_REQ2_REG;
            6'h05: begin
                dec_kind   = K_REQ2_VEC;
                dec_need_a = 1'b1;
                dec_need_b = 1'b1;
            end
            6'h03, 6'h04: begin
                dec_kind   = K_REQ3_REG;
                dec_need_a = 1'b1;
                dec_need_b = 1'b1;
            end
            6'h07: begin
                dec_kind   = K_REQ3_VEC;
                dec_need_a = 1'b1;
                dec_need_b = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        fetch_ready = 1'b0;
        rf_rd_req   = 1'b0;
        rf_rd_id    = '0;
        dx_send     = 1'b0;
        accept      = 1'b0;
        cap_a       = 1'b0;
        cap_b       = 1'b0;
        case (state)
            IDLE: begin
                fetch_ready = reset_n && !flush;
                if (fetch_valid && fetch_ready) begin
                    accept = 1'b1;
                    if (!dec_legal) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                        state_next = ISSUE;
`else
                        state_next = IDLE;
`endif
                    end else begin
                        state_next = dec_need_a ? READ_A : ISSUE;
                    end
                end
            end
            READ_A: begin
                rf_rd_req  = 1'b1;
                rf_rd_id   = src_a;
                state_next = WAIT_A;
            end
            WAIT_A: if (rf_rd_valid) begin
                cap_a      = 1'b1;
                state_next = need_b ? READ_B : ISSUE;
            end
            READ_B: begin
                rf_rd_req  = 1'b1;
                rf_rd_id   = src_b;
                state_next = WAIT_B;
            end
            WAIT_B: if (rf_rd_valid) begin
                cap_b      = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: if (!dx_is_busy) begin
                dx_send    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A redirect wins over everything in flight, including the issue strobe.
        if (flush && state != IDLE) begin
            state_next = IDLE;
            rf_rd_req  = 1'b0;
            rf_rd_id   = '0;
            dx_send    = 1'b0;
            cap_a      = 1'b0;
            cap_b      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_a         <= '0;
            src_b         <= '0;
            need_b        <= 1'b0;
            illegal_seen  <= 1'b0;
            dx_kind       <= K_REQ0;
            dx_opcode     <= '0;
            dx_pc         <= '0;
            dx_exec_mask  <= '0;
            dx_value0_reg <= '0;
            dx_value0_vec <= '0;
            dx_value1     <= '0;
            dx_value2     <= '0;
        end else begin
            if (accept) begin
                src_a  <= REG_ID_W'(fetch_instr[20:16]);
                src_b  <= REG_ID_W'(fetch_instr[15:11]);
                need_b <= dec_need_b;
                if (dec_legal) begin
                    dx_kind       <= dec_kind;
                    dx_opcode     <= op;
                    dx_pc         <= fetch_pc;
                    dx_exec_mask  <= fetch_mask;
                    dx_value0_reg <= (dec_kind == K_REQ2_REG || dec_kind == K_REQ3_REG)
                                     ? REG_ID_W'(fetch_instr[25:21]) : '0;
                    dx_value0_vec <= (dec_kind == K_REQ1) ? imm_v : '0;
                    dx_value1     <= (dec_kind == K_REQ2_REG) ? imm_v : '0;
                    dx_value2     <= (dec_kind == K_REQ3_VEC) ? imm_v : '0;
                end else begin
                    illegal_seen <= 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
                    dx_kind       <= K_REQ0;
                    dx_opcode     <= 6'h3F;
                    dx_pc         <= fetch_pc;
                    dx_exec_mask  <= fetch_mask;
                    dx_value0_reg <= '0;
                    dx_value0_vec <= '0;
                    dx_value1     <= '0;
                    dx_value2     <= '0;
`endif
                end
            end
            // Register-form ops put srcA/srcB in value1/value2; vector-form ops in value0/value1.
            if (cap_a) begin
                if (dx_kind == K_REQ3_REG) dx_value1     <= rf_rd_data;
                else                       dx_value0_vec <= rf_rd_data;
            end
            if (cap_b) begin
                if (dx_kind == K_REQ3_REG) dx_value2 <= rf_rd_data;
                else                       dx_value1 <= rf_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus random legal instructions,
// checked against an opcode-table model and closed-form issue timing.
module tb_decode_stage;

    logic         clk, reset_n;
    logic         fetch_valid, fetch_ready;
    logic [31:0]  fetch_instr, fetch_pc;
    logic [7:0]   fetch_mask;
    logic         flush;
    logic         rf_rd_req, rf_rd_valid;
    logic [4:0]   rf_rd_id;
    logic [255:0] rf_rd_data;
    logic         dx_is_busy, dx_send;
    logic [2:0]   dx_kind;
    logic [7:0]   dx_exec_mask;
    logic [31:0]  dx_pc;
    logic [5:0]   dx_opcode;
    logic [4:0]   dx_value0_reg;
    logic [255:0] dx_value0_vec, dx_value1, dx_value2;
    logic         illegal_seen;

    decode_stage dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_instr(fetch_instr),
        .fetch_pc(fetch_pc), .fetch_mask(fetch_mask), .flush(flush),
        .rf_rd_req(rf_rd_req), .rf_rd_id(rf_rd_id), .rf_rd_valid(rf_rd_valid),
        .rf_rd_data(rf_rd_data), .dx_is_busy(dx_is_busy), .dx_send(dx_send),
        .dx_kind(dx_kind), .dx_exec_mask(dx_exec_mask), .dx_pc(dx_pc),
        .dx_opcode(dx_opcode), .dx_value0_reg(dx_value0_reg), .dx_value0_vec(dx_value0_vec),
        .dx_value1(dx_value1), .dx_value2(dx_value2), .illegal_seen(illegal_seen)
    );

    typedef struct packed {
        logic         send;
        logic [2:0]   kind;
        logic [5:0]   op;
        logic [31:0]  pc;
        logic [7:0]   mask;
        logic [4:0]   v0r;
        logic [255:0] v0v;
        logic [255:0] v1;
        logic [255:0] v2;
        int           nops;
        logic [4:0]   ra;
        logic [4:0]   rb;
    } pkt_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           send_count = 0;
    int           rd_lat = 1;
    logic [255:0] regs [32];
    logic [4:0]   rd_ids [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (dx_send) send_count++;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Register-file responder: answers each request rd_lat cycles later.
    initial begin
        int id;
        rf_rd_valid = 1'b0;
        rf_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rf_rd_req) begin
                id = int'(rf_rd_id);
                rd_ids.push_back(rf_rd_id);
                repeat (rd_lat) @(posedge clk);
                #1 rf_rd_valid = 1'b1;
                rf_rd_data = regs[id];
                @(posedge clk);
                #1 rf_rd_valid = 1'b0;
                rf_rd_data = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] lanes_of(input logic [31:0] w);
        logic [255:0] v;
        for (int l = 0; l < 8; l++) v[l*32 +: 32] = w;
        return v;
    endfunction

    function automatic pkt_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [7:0] mask);
        pkt_t p;
        int imm;
        logic [255:0] immv;
        imm = int'(ins[10:0]);
        if (imm >= 1024) imm = imm - 2048;
        immv = lanes_of(32'(imm));
        p = '0;
        p.send = 1'b1;
        p.op   = ins[31:26];
        p.pc   = pc;
        p.mask = mask;
        p.ra   = ins[20:16];
        p.rb   = ins[15:11];
        case (int'(ins[31:26]))
            0, 1: p.kind = 3'd0;
            6: begin p.kind = 3'd1; p.v0v = immv; end
            2: begin p.kind = 3'd2; p.v0r = ins[25:21]; p.v1 = immv; end
            5: begin p.kind = 3'd3; p.v0v = regs[p.ra]; p.v1 = regs[p.rb]; p.nops = 2; end
            3, 4: begin
                p.kind = 3'd4; p.v0r = ins[25:21];
                p.v1 = regs[p.ra]; p.v2 = regs[p.rb]; p.nops = 2;
            end
            7: begin
                p.kind = 3'd5; p.v0v = regs[p.ra]; p.v1 = regs[p.rb];
                p.v2 = immv; p.nops = 2;
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                p.kind = 3'd0;
                p.op   = 6'h3F;
`else
                p.send = 1'b0;
`endif
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] enc(input int op, input int d, input int a,
                                        input int b, input int imm);
        return {6'(op), 5'(d), 5'(a), 5'(b), 11'(imm)};
    endfunction

    task automatic check_pkt(input pkt_t e);
        check("kind",   dx_kind,       e.kind);
        check("opcode", dx_opcode,     e.op);
        check("pc",     dx_pc,         e.pc);
        check("mask",   dx_exec_mask,  e.mask);
        check("v0reg",  dx_value0_reg, e.v0r);
        check("v0vec",  dx_value0_vec, e.v0v);
        check("value1", dx_value1,     e.v1);
        check("value2", dx_value2,     e.v2);
    endtask

    // Present one instruction at posedge+1 and follow it until issue (or drop).
    task automatic do_instr(input logic [31:0] ins, input logic [31:0] pc,
                            input logic [7:0] mask, input int lat, input int stall);
        pkt_t e;
        int lat0, exp_k, got_k, sends0;
        e      = model(ins, pc, mask);
        rd_lat = lat;
        rd_ids.delete();
        lat0   = (e.nops == 2) ? 2 * lat + 3 : 1;
        exp_k  = lat0 + stall;
        sends0 = send_count;
        fetch_instr = ins;
        fetch_pc    = pc;
        fetch_mask  = mask;
        fetch_valid = 1'b1;
        dx_is_busy  = (stall > 0);
        @(negedge clk);
        check("fetch_ready_idle", fetch_ready, 1'b1);
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        if (!e.send) begin
            dx_is_busy = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                check("no_send_drop", dx_send, 1'b0);
                if (k == 1) check("ready_after_drop", fetch_ready, 1'b1);
                @(posedge clk); #1;
            end
        end else begin
            got_k = -1;
            for (int k = 1; k <= exp_k + 20 && got_k < 0; k++) begin
                dx_is_busy = (k < exp_k) && (stall > 0);
                @(negedge clk);
                if (dx_send) got_k = k;
                if (k >= lat0 && k <= exp_k) check_pkt(e);
                @(posedge clk); #1;
            end
            dx_is_busy = 1'b0;
            check("send_cycle", got_k, exp_k);
            @(negedge clk);
            check("send_low_after", dx_send, 1'b0);
            check("rd_count", rd_ids.size(), e.nops);
            if (e.nops == 2 && rd_ids.size() == 2) begin
                check("rd_id_a", rd_ids[0], e.ra);
                check("rd_id_b", rd_ids[1], e.rb);
            end
            @(posedge clk); #1;
            check("send_once", send_count - sends0, 1);
        end
    endtask

    // Accept an instruction, flush at cycle flush_k, and expect nothing to issue.
    task automatic flush_run(input logic [31:0] ins, input int lat, input int flush_k,
                             input logic busy);
        int sends0;
        rd_lat = lat;
        sends0 = send_count;
        fetch_instr = ins;
        fetch_pc    = 32'h40;
        fetch_mask  = 8'h0F;
        fetch_valid = 1'b1;
        dx_is_busy  = busy;
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            flush      = (k == flush_k);
            dx_is_busy = busy && (k <= flush_k);
            @(negedge clk);
            check("flush_no_send", dx_send, 1'b0);
            if (k == flush_k + 1) check("flush_idle_ready", fetch_ready, 1'b1);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        check("flush_send_count", send_count - sends0, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        fetch_valid = 1'b0;
        fetch_instr = '0;
        fetch_pc    = '0;
        fetch_mask  = '0;
        flush       = 1'b0;
        dx_is_busy  = 1'b0;
        for (int r = 0; r < 32; r++)
            for (int l = 0; l < 8; l++) regs[r][l*32 +: 32] = $urandom;

        repeat (2) @(negedge clk);
        check("rst_fetch_ready", fetch_ready, 1'b0);
        check("rst_dx_send", dx_send, 1'b0);
        check("rst_rf_rd_req", rf_rd_req, 1'b0);
        check("rst_illegal", illegal_seen, 1'b0);
        check("rst_kind", dx_kind, 3'd0);
        check("rst_pc", dx_pc, 32'd0);
        check("rst_value1", dx_value1, 256'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) check("ready_after_reset", fetch_ready, 1'b1);
            check("idle_no_send", dx_send, 1'b0);
            @(posedge clk); #1;
        end

        // LOADI dst=3 imm=-2
        do_instr(enc(2, 3, 0, 0, -2), 32'h100, 8'hFF, 1, 0);
        // ADD dst=1 srcA=2 srcB=4, latency 2
        regs[2] = lanes_of(32'd5);
        regs[4] = lanes_of(32'd7);
        do_instr(enc(3, 1, 2, 4, 0), 32'h104, 8'hA5, 2, 0);
        // BEQ with a 4-cycle bus stall in ISSUE
        do_instr(enc(7, 0, 6, 9, 12), 32'h108, 8'h3C, 1, 4);
        // Zero-operand ops with and without stall
        do_instr(enc(6, 0, 0, 0, 1023), 32'h10C, 8'h01, 1, 0);
        do_instr(enc(0, 0, 0, 0, 0), 32'h110, 8'hFF, 1, 2);
        // Flush during WAIT_B of STORE (late read data arrives afterwards), then NOP
        flush_run(enc(5, 0, 9, 10, 0), 3, 6, 1'b0);
        do_instr(enc(0, 0, 0, 0, 0), 32'h200, 8'hF0, 1, 0);
        // Flush while stalled in ISSUE, then HALT
        flush_run(enc(0, 0, 0, 0, 0), 1, 2, 1'b1);
        do_instr(enc(1, 0, 0, 0, 0), 32'h204, 8'h81, 1, 0);

        for (int i = 0; i < 30; i++) begin
            do_instr(enc(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 2047))),
                     $urandom, 8'($urandom), int'($urandom_range(1, 4)),
                     int'($urandom_range(0, 3)));
        end

        check("illegal_before", illegal_seen, 1'b0);
        do_instr(enc(6'h2A, 7, 1, 2, 5), 32'h300, 8'h77, 1, 0);
        check("illegal_after", illegal_seen, 1'b1);
        do_instr(enc(4, 8, 11, 12, 0), 32'h304, 8'hFF, 3, 1);
        check("illegal_sticky", illegal_seen, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the vector core. It accepts one fetched instruction at a time together with its PC and execution mask, and decodes the opcode and operands. Vector source operands are read through a single-port register-file read interface. The result is issued as one packet to the decode-to-execute bus, sitting between fetch and the execute stage.

## Interface
Parameters:
- NUM_LANES, 8: vector lanes; VectorValue width = NUM_LANES*WORD_W
- WORD_W, 32: lane word width
- ADDR_W, 32: memory_address_t width
- REG_ID_W, 5: RegisterID width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- fetch_valid  in  1  instruction available
- fetch_ready  out  1  stage accepts instruction this cycle
- fetch_instr  in  32  [31:26] op, [25:21] dst, [20:16] srcA, [15:11] srcB, [10:0] imm11
- fetch_pc  in  ADDR_W  instruction PC
- fetch_mask  in  NUM_LANES  execution_mask_t
- flush  in  1  execute-side redirect; abort current instruction
- rf_rd_req  out  1  one-cycle register read request
- rf_rd_id  out  REG_ID_W  register to read
- rf_rd_valid  in  1  read data valid (variable latency ≥1)
- rf_rd_data  in  NUM_LANES*WORD_W  vector read data
- dx_is_busy  in  1  bus holds an unconsumed packet
- dx_send  out  1  one-cycle issue strobe
- dx_kind  out  3  0=req0, 1=req1, 2=req2_reg, 3=req2_vec, 4=req3_reg, 5=req3_vec
- dx_exec_mask, dx_pc, dx_opcode(6)  out  packet header
- dx_value0_reg  out  REG_ID_W  destination register
- dx_value0_vec, dx_value1, dx_value2  out  NUM_LANES*WORD_W  vector operands
- illegal_seen  out  1  sticky illegal-opcode flag

## Operation
- FSM states: IDLE, READ_A, WAIT_A, READ_B, WAIT_B, ISSUE.
- IDLE: fetch_ready=1 unless flush is high. On fetch_valid&&fetch_ready, latch instr/pc/mask, decode, and go to READ_A if srcA is needed, else ISSUE.
- READ_x: pulse rf_rd_req with the register id, then go to WAIT_x. WAIT_x: on rf_rd_valid, capture the data and go to READ_B (if srcB is needed) or ISSUE.
- ISSUE: if !dx_is_busy, pulse dx_send with the packet and go to IDLE. Otherwise hold all dx_* outputs stable.
- imm vector = sign-extended imm11 replicated to every lane.
- Decode:
  - 0x00 NOP, 0x01 HALT: kind 0.
  - 0x06 JMP: kind 1, value0_vec=imm vector.
  - 0x02 LOADI: kind 2, value0_reg=dst, value1=imm vector.
  - 0x05 STORE: kind 3, value0_vec=R[srcA], value1=R[srcB].
  - 0x03 ADD, 0x04 SUB: kind 4, value0_reg=dst, value1=R[srcA], value2=R[srcB].
  - 0x07 BEQ: kind 5, value0_vec=R[srcA], value1=R[srcB], value2=imm vector.
- Unused value fields are driven to 0.
- Any other opcode is illegal: illegal_seen sets and stays set until reset (see Configuration).
- flush in any non-IDLE state: return to IDLE next cycle and send nothing. A pending rf_rd_valid after a flush is ignored until the next READ state issues a request. At most one read is outstanding.
- flush and dx_send never occur in the same cycle: flush has priority and suppresses dx_send.

## Timing
- Reset values: fetch_ready=0 while reset_n is low, then 1 in IDLE. rf_rd_req=0, dx_send=0, all dx_* fields=0, illegal_seen=0, state=IDLE.
- Zero-operand instruction accepted at cycle T: dx_send at T+1 if the bus is free.
- Two-operand instruction with read latency L: dx_send at T+2L+3 minimum.
- Throughput: one instruction per (latency+1) cycles. No overlap between instructions.
- dx_is_busy is sampled in ISSUE. A stall of N cycles delays dx_send by exactly N cycles.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: an illegal opcode issues kind 0 with dx_opcode=6'h3F (TRAP) and the original PC and mask, so execute raises the fault.
- DECODE_ILLEGAL_TRAP_EN undefined: an illegal opcode is dropped silently and the FSM returns to IDLE at T+1.
- illegal_seen sets in both cases.

## Test plan
- Reset release with fetch_valid=0 → fetch_ready=1, and no dx_send for 10 cycles.
- LOADI dst=3 imm=-2 at PC 0x100, mask 0xFF → one dx_send at T+1: kind=2, value0_reg=3, every lane of value1=0xFFFFFFFE.
- ADD dst=1 srcA=2 srcB=4 with L=2, R2 lanes=5, R4 lanes=7 → rf reads issued for 2 then 4, then kind=4 with value1 lanes=5, value2 lanes=7 at T+7.
- BEQ with dx_is_busy held high for 4 cycles in ISSUE → dx_* stable throughout, and dx_send occurs exactly once, on the first cycle busy is low.
- flush asserted during WAIT_B of STORE, then a late rf_rd_valid → no dx_send, state returns to IDLE, and the next NOP issues correctly.
- Opcode 0x2A → illegal_seen=1. With DECODE_ILLEGAL_TRAP_EN: kind=0 and dx_opcode=0x3F. Without it: no dx_send.
